// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter
//
// Round-robin arbiter that lets four requesters share one single-port RAM
// with a 1-cycle registered read latency.
//
//   IDLE      : pick the next requester round-robin and register its grant.
//   GRANT     : drive the owner's address/data to the RAM. A write completes
//               here (write strobe + ack). A read moves on to READ_WAIT. If
//               the owner has dropped its request, the access is cancelled.
//   READ_WAIT : RAM data is valid. Ack the owner and forward the data.
//
// Requesters hold iReq/iWrite/iAddr/iData stable until their oAck. The
// arbiter does not capture them; it steers them straight to the RAM.
//
// Optional feature (macro ARBITER_LOCK_EN):
//   Adds the iLock port. If iLock[g] and iReq[g] are both high in g's ack
//   cycle, g is granted again immediately, without arbitration, and the
//   round-robin pointer does not move.
//
// Ports:
//   Clock, Reset       clock; asynchronous active-low reset
//   iReq[3:0]          per-requester access request
//   iWrite[3:0]        per-requester 1 = write, 0 = read
//   iAddr              requester k address at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   iData              requester k write data at [k*DATA_WIDTH +: DATA_WIDTH]
//   iLock[3:0]         per-requester grant hold (ARBITER_LOCK_EN only)
//   oGrant[3:0]        one-hot current owner
//   oAck[3:0]          one-cycle completion pulse
//   oReadData          read result, valid with a read oAck, else 0
//   oBusy              high whenever the FSM is not in IDLE
//   oRamWriteEnable    RAM write strobe
//   oRamAddress        RAM address (0 outside GRANT)
//   oRamDataIn         RAM write data (0 outside GRANT)
//   iRamDataOut        RAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module ram_access_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [3:0]              iReq,
    input  logic [3:0]              iWrite,
    input  logic [4*ADDR_WIDTH-1:0] iAddr,
    input  logic [4*DATA_WIDTH-1:0] iData,
`ifdef ARBITER_LOCK_EN
    input  logic [3:0]              iLock,
`endif
    output logic [3:0]              oGrant,
    output logic [3:0]              oAck,
    output logic [DATA_WIDTH-1:0]   oReadData,
    output logic                    oBusy,
    output logic                    oRamWriteEnable,
    output logic [ADDR_WIDTH-1:0]   oRamAddress,
    output logic [DATA_WIDTH-1:0]   oRamDataIn,
    input  logic [DATA_WIDTH-1:0]   iRamDataOut
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_READ_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_grant;
    // r_last is the most recently granted index. Outside IDLE it is also
    // the current owner's index, because every grant loads it. A locked
    // re-grant keeps the same owner, so the value still matches.
    logic [1:0] r_last;

    logic                  w_req_g;
    logic                  w_write_g;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_write_done;
    logic                  w_read_done;
    logic                  w_lock_hold;
    logic [1:0]            w_pick_idx;
    logic [1:0]            w_cand;
    logic                  w_found;

    // Inputs of the current owner.
    assign w_req_g    = iReq[r_last];
    assign w_write_g  = iWrite[r_last];
    assign w_sel_addr = iAddr[int'(r_last)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_data = iData[int'(r_last)*DATA_WIDTH +: DATA_WIDTH];

    // A write finishes in GRANT only if the owner still requests it.
    // Otherwise the access is a cancel.
    assign w_write_done = (r_state == ST_GRANT) && w_req_g && w_write_g;
    assign w_read_done  = (r_state == ST_READ_WAIT);

`ifdef ARBITER_LOCK_EN
    assign w_lock_hold = iLock[r_last] & iReq[r_last];
`else
    assign w_lock_hold = 1'b0;
`endif

    // Round-robin search: candidates r_last+1, r_last+2, r_last+3 and
    // finally r_last itself. The 2-bit arithmetic wraps modulo 4.
    // NOTE: every variable assigned in always_comb gets a default first,
    // so no path leaves it unassigned. Otherwise the tool infers a latch.
    always_comb begin
        w_pick_idx = r_last;
        w_cand     = '0;
        w_found    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w_cand = r_last + i[1:0];
            if (!w_found && iReq[w_cand]) begin
                w_pick_idx = w_cand;
                w_found    = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from values sampled before the edge, and the
    // order of the statements does not matter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_last  <= 2'd3;     // requester 0 wins the first arbitration
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|iReq) begin
                        r_state <= ST_GRANT;
                        r_grant <= 4'b0001 << w_pick_idx;
                        r_last  <= w_pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (!w_req_g) begin
                        r_state <= ST_IDLE;          // cancelled
                        r_grant <= 4'b0000;
                    end else if (w_write_g) begin
                        if (!w_lock_hold) begin
                            r_state <= ST_IDLE;
                            r_grant <= 4'b0000;
                        end
                    end else begin
                        r_state <= ST_READ_WAIT;
                    end
                end
                ST_READ_WAIT: begin
                    if (w_lock_hold) begin
                        r_state <= ST_GRANT;
                    end else begin
                        r_state <= ST_IDLE;
                        r_grant <= 4'b0000;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 4'b0000;
                end
            endcase
        end
    end

    // The write ack and the write strobe must react to iReq inside the
    // GRANT cycle, because a cancel is only visible there. For that reason
    // these outputs are decoded from the registered state and the live
    // inputs, not registered themselves. Reset forces the state to IDLE
    // asynchronously, so every output drops to 0 without waiting for an edge.
    assign oGrant          = r_grant;
    assign oBusy           = (r_state != ST_IDLE);
    assign oRamWriteEnable = w_write_done;
    assign oAck            = (w_write_done || w_read_done) ? r_grant : 4'b0000;
    assign oReadData       = w_read_done ? iRamDataOut : '0;
    assign oRamAddress     = (r_state == ST_GRANT) ? w_sel_addr : '0;
    assign oRamDataIn      = (r_state == ST_GRANT) ? w_sel_data : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_access_arbiter
//
// Bench for ram_access_arbiter.
//
// A behavioural model tracks the current owner (or none) and whether the
// owner is still in its address cycle or in its read-data cycle. It also
// keeps a shadow copy of the RAM contents. From these the model computes
// every output on each falling clock edge and compares it with the DUT.
// A simple RAM with a 1-cycle registered read is attached to the DUT.
// Directed sequences pin the key behaviours to hand-computed literals.
// Randomized traffic with cancels (and locks, when ARBITER_LOCK_EN is
// defined) follows the directed sequences.
// ---------------------------------------------------------------------------
module tb_ram_access_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;

    logic            Clock = 1'b0;
    logic            Reset = 1'b0;
    logic [3:0]      iReq = '0;
    logic [3:0]      iWrite = '0;
    logic [4*AW-1:0] iAddr = '0;
    logic [4*DW-1:0] iData = '0;
`ifdef ARBITER_LOCK_EN
    logic [3:0]      iLock = '0;
`endif
    logic [3:0]      oGrant;
    logic [3:0]      oAck;
    logic [DW-1:0]   oReadData;
    logic            oBusy;
    logic            oRamWriteEnable;
    logic [AW-1:0]   oRamAddress;
    logic [DW-1:0]   oRamDataIn;
    logic [DW-1:0]   iRamDataOut;

    int n_checks = 0;
    int n_errors = 0;

    ram_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .iReq            (iReq),
        .iWrite          (iWrite),
        .iAddr           (iAddr),
        .iData           (iData),
`ifdef ARBITER_LOCK_EN
        .iLock           (iLock),
`endif
        .oGrant          (oGrant),
        .oAck            (oAck),
        .oReadData       (oReadData),
        .oBusy           (oBusy),
        .oRamWriteEnable (oRamWriteEnable),
        .oRamAddress     (oRamAddress),
        .oRamDataIn      (oRamDataIn),
        .iRamDataOut     (iRamDataOut)
    );

    always #5 Clock = ~Clock;

    // Attached RAM: 256 words are enough, because the bench uses only low
    // addresses. The read data is registered.
    logic [DW-1:0] ram [256] = '{default: '0};
    always @(posedge Clock) begin
        if (oRamWriteEnable) ram[oRamAddress[7:0]] <= oRamDataIn;
        iRamDataOut <= ram[oRamAddress[7:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int            m_owner = -1;   // -1: nobody owns the RAM
    bit            m_rd    = 1'b0; // owner is in its read-data cycle
    int            m_last  = 3;
    logic [DW-1:0] m_mem [256] = '{default: '0};
    logic [3:0]    seen_ack = '0;  // acks of the cycle just compared
    int            n_wr = 0, n_rdc = 0, n_cancel = 0;

    always @(negedge Clock or negedge Reset) begin
        logic [3:0]    e_grant, e_ack;
        logic          e_we, e_busy;
        logic [AW-1:0] a;
        logic [DW-1:0] d, e_addr_dat, e_din, e_rd;
        logic [AW-1:0] e_addr;
        bit            lock_hold;
        if (!Reset) begin
            m_owner  = -1;
            m_rd     = 1'b0;
            m_last   = 3;
            seen_ack = '0;
        end else begin
            e_grant = '0; e_ack = '0; e_we = 1'b0; e_busy = 1'b0;
            e_addr = '0; e_din = '0; e_rd = '0; e_addr_dat = '0;
            a = '0; d = '0;
            if (m_owner >= 0) begin
                e_grant = 4'(1 << m_owner);
                e_busy  = 1'b1;
                a = iAddr[m_owner*AW +: AW];
                d = iData[m_owner*DW +: DW];
                if (!m_rd) begin
                    e_addr = a;
                    e_din  = d;
                    if (iReq[m_owner] && iWrite[m_owner]) begin
                        e_we  = 1'b1;
                        e_ack = e_grant;
                    end
                end else begin
                    e_ack = e_grant;
                    e_rd  = m_mem[a[7:0]];
                end
            end
            check("grant",    64'(oGrant),          64'(e_grant));
            check("ack",      64'(oAck),            64'(e_ack));
            check("busy",     64'(oBusy),           64'(e_busy));
            check("ram_we",   64'(oRamWriteEnable), 64'(e_we));
            check("ram_addr", 64'(oRamAddress),     64'(e_addr));
            check("ram_din",  64'(oRamDataIn),      64'(e_din));
            check("rdata",    64'(oReadData),       64'(e_rd));
            seen_ack = oAck;

            // Advance the model to the next cycle.
            lock_hold = 1'b0;
`ifdef ARBITER_LOCK_EN
            if (m_owner >= 0) lock_hold = iLock[m_owner] && iReq[m_owner];
`endif
            if (m_owner < 0) begin
                for (int i = 1; i <= 4; i++) begin
                    if (iReq[(m_last + i) % 4]) begin
                        m_owner = (m_last + i) % 4;
                        m_last  = m_owner;
                        m_rd    = 1'b0;
                        break;
                    end
                end
            end else if (!m_rd) begin
                if (!iReq[m_owner]) begin
                    m_owner = -1;
                    n_cancel++;
                end else if (iWrite[m_owner]) begin
                    m_mem[a[7:0]] = d;
                    n_wr++;
                    if (!lock_hold) m_owner = -1;
                end else begin
                    m_rd = 1'b1;
                end
            end else begin
                n_rdc++;
                m_rd = 1'b0;
                if (!lock_hold) m_owner = -1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_txn(input int k, input bit wr, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        iReq[k]           = 1'b1;
        iWrite[k]         = wr;
        iAddr[k*AW +: AW] = ad;
        iData[k*DW +: DW] = dt;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(oGrant), 64'd0);
        check({tag, "_ack"},   64'(oAck), 64'd0);
        check({tag, "_busy"},  64'(oBusy), 64'd0);
        check({tag, "_we"},    64'(oRamWriteEnable), 64'd0);
        check({tag, "_addr"},  64'(oRamAddress), 64'd0);
        check({tag, "_din"},   64'(oRamDataIn), 64'd0);
        check({tag, "_rdata"}, 64'(oReadData), 64'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        iReq  = '0;
        iWrite = '0;
`ifdef ARBITER_LOCK_EN
        iLock = '0;
`endif
        repeat (2) next_cycle();
        check_all_zero("rst");
        Reset = 1'b1;
    endtask

    logic [3:0] active;
    int         order [$];
    int         times [$];

    initial begin
        do_reset();

        // Single write: requester 0 writes 0xDEADBEEF to 0x0010.
        next_cycle();
        set_txn(0, 1'b1, 16'h0010, 32'hDEADBEEF);
        @(negedge Clock);
        check("wr_idle_grant", 64'(oGrant), 64'h0);
        next_cycle();
        @(negedge Clock);
        check("wr_grant", 64'(oGrant), 64'h1);
        check("wr_we",    64'(oRamWriteEnable), 64'h1);
        check("wr_ack",   64'(oAck), 64'h1);
        check("wr_addr",  64'(oRamAddress), 64'h0010);
        next_cycle();
        iReq = '0;
        check("wr_ram_word", 64'(ram[8'h10]), 64'hDEADBEEF);
        @(negedge Clock);
        check("wr_after_grant", 64'(oGrant), 64'h0);

        // Read-back by requester 2.
        next_cycle();
        set_txn(2, 1'b0, 16'h0010, 32'h0);
        next_cycle();
        @(negedge Clock);
        check("rd_grant", 64'(oGrant), 64'h4);
        check("rd_ack_early", 64'(oAck), 64'h0);
        next_cycle();
        @(negedge Clock);
        check("rd_ack",   64'(oAck), 64'h4);
        check("rd_data",  64'(oReadData), 64'hDEADBEEF);
        next_cycle();
        iReq = '0;
        @(negedge Clock);
        check("rd_after_grant", 64'(oGrant), 64'h0);

        // Fairness: all four requesters write continuously from reset.
        do_reset();
        for (int k = 0; k < 4; k++) set_txn(k, 1'b1, 16'(16'h20 + k), $urandom);
        for (int c = 0; c < 20 && order.size() < 5; c++) begin
            @(negedge Clock);
            if (oAck != 0) begin
                order.push_back($clog2(oAck));
                times.push_back(c);
            end
        end
        check("fair_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < order.size(); i++) begin
            check("fair_order", 64'(order[i]), 64'(i % 4));
            if (i > 0) check("fair_spacing", 64'(times[i] - times[i-1]), 64'd2);
        end
        next_cycle();
        iReq = '0;
        repeat (3) next_cycle();

        // Cancel: requester 1 drops its request in its GRANT cycle.
        set_txn(1, 1'b1, 16'h0040, 32'h12345678);
        next_cycle();
        iReq[1] = 1'b0;
        @(negedge Clock);
        check("cxl_grant", 64'(oGrant), 64'h2);
        check("cxl_we",    64'(oRamWriteEnable), 64'h0);
        check("cxl_ack",   64'(oAck), 64'h0);
        next_cycle();
        @(negedge Clock);
        check("cxl_idle", 64'(oBusy), 64'h0);
        // rLast is now 1, so with requests 0 and 1 the search visits 2,3,0.
        set_txn(0, 1'b1, 16'h0041, 32'h1);
        set_txn(1, 1'b1, 16'h0042, 32'h2);
        next_cycle();
        @(negedge Clock);
        check("cxl_next_grant", 64'(oGrant), 64'h1);
        next_cycle();
        iReq = '0;
        repeat (2) next_cycle();

        // Reset abort during a write GRANT by requester 3.
        set_txn(3, 1'b1, 16'h0030, 32'hCAFEF00D);
        next_cycle();
        @(negedge Clock);
        check("abort_we_before", 64'(oRamWriteEnable), 64'h1);
        #2 Reset = 1'b0;
        #1 check_all_zero("abort");
        next_cycle();
        check("abort_no_write", 64'(ram[8'h30]), 64'h0);
        next_cycle();
        Reset = 1'b1;                 // iReq = 1000 is still held
        next_cycle();
        @(negedge Clock);
        check("abort_regrant", 64'(oGrant), 64'h8);
        next_cycle();
        iReq = '0;
        repeat (2) next_cycle();

`ifdef ARBITER_LOCK_EN
        // Lock: requester 0 keeps the RAM for three writes, then 1 gets it.
        do_reset();
        set_txn(0, 1'b1, 16'h0050, 32'hA0);
        set_txn(1, 1'b1, 16'h0051, 32'hA1);
        iLock = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            next_cycle();
            if (n == 2) iLock = 4'b0000;
            @(negedge Clock);
            check("lock_grant", 64'(oGrant), 64'h1);
            check("lock_ack",   64'(oAck), 64'h1);
        end
        next_cycle();
        @(negedge Clock);
        check("lock_gap", 64'(oGrant), 64'h0);
        next_cycle();
        @(negedge Clock);
        check("lock_next", 64'(oGrant), 64'h2);
        next_cycle();
        iReq = '0;
        repeat (2) next_cycle();
`endif

        // Randomized traffic, checked cycle by cycle against the model.
        do_reset();
        active = '0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            for (int k = 0; k < 4; k++) begin
                if (active[k] && seen_ack[k]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_txn(k, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
                    else begin
                        active[k] = 1'b0;
                        iReq[k]   = 1'b0;
                    end
                end else if (active[k] && m_owner == k && !m_rd && $urandom_range(0, 9) == 0) begin
                    active[k] = 1'b0;     // cancel in the GRANT cycle
                    iReq[k]   = 1'b0;
                end else if (!active[k] && $urandom_range(0, 2) == 0) begin
                    active[k] = 1'b1;
                    set_txn(k, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
                end
`ifdef ARBITER_LOCK_EN
                iLock[k] = ($urandom_range(0, 3) == 0);
`endif
            end
        end
        iReq = '0;
        repeat (4) next_cycle();

        check("cov_writes",  64'(n_wr > 0), 64'd1);
        check("cov_reads",   64'(n_rdc > 0), 64'd1);
        check("cov_cancels", 64'(n_cancel > 0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
